// File: rtl/mv_spimaster_multi.sv
// mv_spimaster_multi: parametrised full-duplex SPI master.
// One word per request, with configurable width, SCLK divider, per-transfer
// CPOL/CPHA, bit order and chip-select hold across consecutive words.
module mv_spimaster_multi #(
    parameter int DATA_W   = 8,
    parameter int NUM_CS   = 4,
    parameter int CS_SEL_W = 2,
    parameter int CLK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rw_req,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [CS_SEL_W-1:0] cs_sel,
    input  logic                cpol,
    input  logic                cpha,
    input  logic                lsb_first,
    input  logic                hold_cs,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_strobe,
    output logic                ready,
    output logic                sclk,
    output logic                mosi,
    input  logic                miso,
    output logic [NUM_CS-1:0]   cs_n
);

    localparam int HC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BC_W = $clog2(DATA_W + 1);
    localparam logic [HC_W-1:0] HC_LOAD = HC_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_GAP,
        S_CS_SETUP,
        S_LEAD,
        S_TRAIL,
        S_CS_HOLD,
        S_DONE
    } state_t;

    state_t state;
    state_t next_state;

    // Half-period and bit counters
    logic [HC_W-1:0] hcnt;
    logic [HC_W-1:0] hcnt_d;
    logic [BC_W-1:0] bcnt;
    logic [BC_W-1:0] bcnt_d;

    // Shift registers
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] tx_d;
    logic [DATA_W-1:0] rx_sh;
    logic [DATA_W-1:0] rx_d;

    // Configuration captured when a request is accepted
    logic [CS_SEL_W-1:0] cs_sel_q;
    logic                cpol_q;
    logic                cpha_q;
    logic                lsb_q;
    logic                hold_q;

    // Next values of the registered outputs
    logic              sclk_d;
    logic              mosi_d;
    logic [NUM_CS-1:0] cs_n_d;
    logic [DATA_W-1:0] rd_data_d;
    logic              rd_strobe_d;
    logic              ready_d;

    // Control terms shared by the combinational processes
    logic                accept;
    logic                hc_zero;
    logic                need_gap;
    logic                entering;
    logic                drive;
    logic                sample;
    logic                c_pol;
    logic                c_pha;
    logic                c_lsb;
    logic [CS_SEL_W-1:0] c_sel;
    logic [DATA_W-1:0]   tx_cur;

    // Active-low select pattern for one slave; out-of-range index selects none
    function automatic logic [NUM_CS-1:0] sel_mask(input logic [CS_SEL_W-1:0] sel);
        logic [NUM_CS-1:0] m;
        m = '1;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            if (32'(sel) == i) begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    assign accept   = (state == S_IDLE) && rw_req;
    assign hc_zero  = (hcnt == '0);
    // A held select for another slave must be released for one half-period
    assign need_gap = (cs_n != '1) && (cs_sel != cs_sel_q);
    assign entering = (next_state != state);

    // On the acceptance edge the inputs are used directly, before they are latched
    assign c_pol  = accept ? cpol      : cpol_q;
    assign c_pha  = accept ? cpha      : cpha_q;
    assign c_lsb  = accept ? lsb_first : lsb_q;
    assign c_sel  = accept ? cs_sel    : cs_sel_q;
    assign tx_cur = accept ? wr_data   : tx_sh;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: every timed state lasts one half-period
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (rw_req) begin
                    next_state = need_gap ? S_CS_GAP : S_CS_SETUP;
                end
            end
            S_CS_GAP: begin
                if (hc_zero) next_state = S_CS_SETUP;
            end
            S_CS_SETUP: begin
                if (hc_zero) next_state = S_LEAD;
            end
            S_LEAD: begin
                if (hc_zero) next_state = S_TRAIL;
            end
            S_TRAIL: begin
                if (hc_zero) next_state = (bcnt != '0) ? S_LEAD : S_CS_HOLD;
            end
            S_CS_HOLD: begin
                if (hc_zero) next_state = S_DONE;
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Output and datapath next values, keyed on the state being entered
    always_comb begin
        sclk_d      = sclk;
        mosi_d      = mosi;
        cs_n_d      = cs_n;
        rd_data_d   = rd_data;
        rd_strobe_d = 1'b0;
        ready_d     = (next_state == S_IDLE);
        tx_d        = accept ? wr_data : tx_sh;
        rx_d        = accept ? '0 : rx_sh;
        drive       = 1'b0;

        hcnt_d = entering ? HC_LOAD : (hc_zero ? hcnt : hcnt - HC_W'(1));
        if (accept) begin
            bcnt_d = BC_W'(DATA_W);
        end else if (entering && (next_state == S_TRAIL)) begin
            bcnt_d = bcnt - BC_W'(1);
        end else begin
            bcnt_d = bcnt;
        end

        // miso is captured at the end of the sampling half-period
        sample = hc_zero &&
                 (((state == S_LEAD) && !cpha_q) || ((state == S_TRAIL) && cpha_q));
        if (sample) begin
            rx_d = lsb_q ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};
        end

        case (next_state)
            S_IDLE: begin
                sclk_d = cpol;
                mosi_d = 1'b0;
            end
            S_CS_GAP: begin
                sclk_d = c_pol;
                mosi_d = 1'b0;
                cs_n_d = '1;
            end
            S_CS_SETUP: begin
                sclk_d = c_pol;
                cs_n_d = sel_mask(c_sel);
                drive  = entering && !c_pha;
            end
            S_LEAD: begin
                sclk_d = ~c_pol;
                drive  = entering && c_pha;
            end
            S_TRAIL: begin
                sclk_d = c_pol;
                // bcnt still counts the bit in flight here; 1 means it was the last
                drive  = entering && !c_pha && (bcnt != BC_W'(1));
            end
            S_CS_HOLD: begin
                sclk_d = c_pol;
                mosi_d = 1'b0;
            end
            S_DONE: begin
                sclk_d      = c_pol;
                mosi_d      = 1'b0;
                rd_data_d   = rx_sh;
                rd_strobe_d = 1'b1;
                cs_n_d      = hold_q ? cs_n : '1;
            end
            default: begin
                sclk_d = c_pol;
            end
        endcase

        if (drive) begin
            mosi_d = c_lsb ? tx_cur[0] : tx_cur[DATA_W-1];
            tx_d   = c_lsb ? (tx_cur >> 1) : (tx_cur << 1);
        end
    end

    // Registered outputs, counters, shift registers and latched configuration
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt      <= '0;
            bcnt      <= '0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            cs_sel_q  <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            hold_q    <= 1'b0;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            cs_n      <= '1;
            rd_data   <= '0;
            rd_strobe <= 1'b0;
            ready     <= 1'b1;
        end else begin
            hcnt      <= hcnt_d;
            bcnt      <= bcnt_d;
            tx_sh     <= tx_d;
            rx_sh     <= rx_d;
            sclk      <= sclk_d;
            mosi      <= mosi_d;
            cs_n      <= cs_n_d;
            rd_data   <= rd_data_d;
            rd_strobe <= rd_strobe_d;
            ready     <= ready_d;
            if (accept) begin
                cs_sel_q <= cs_sel;
                cpol_q   <= cpol;
                cpha_q   <= cpha;
                lsb_q    <= lsb_first;
                hold_q   <= hold_cs;
            end
        end
    end

endmodule

// File: tb/tb_mv_spimaster_multi.sv
// Testbench for mv_spimaster_multi: three builds (8-bit/div2, 16-bit/div2,
// 8-bit/div1) driven by directed and random transfers, checked against a
// transaction-level model and an edge-driven SPI slave.
module tb_mv_spimaster_multi;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Per-build parameters
    int DWV [3] = '{8, 16, 8};
    int CDV [3] = '{2, 2, 1};

    // Per-build inputs
    logic        rw_req  [3];
    logic [31:0] wr_data [3];
    logic [2:0]  cs_sel  [3];
    logic        cpol    [3];
    logic        cpha    [3];
    logic        lsbf    [3];
    logic        hold    [3];
    logic        miso;

    // Per-build outputs
    logic [7:0]  rd0, rd2;
    logic [15:0] rd1;
    logic        stb0, stb1, stb2, rdy0, rdy1, rdy2;
    logic        sck0, sck1, sck2, mo0, mo1, mo2;
    logic [3:0]  csn0, csn1, csn2;

    // Outputs of the build under test
    int          cur = 0;
    logic [31:0] o_rd;
    logic        o_stb, o_rdy, o_sclk, o_mosi;
    logic [3:0]  o_csn;

    // Slave-side state
    logic        lp = 1'b0;
    logic        s_miso;
    logic        arm = 1'b0;
    logic        armed_q = 1'b0;
    logic        m_pol, m_pha, m_lsb;
    int          m_w = 8;
    logic [31:0] m_sdata;
    int          idx, n_lead, n_trail, n_cap, mo_bad;
    logic [31:0] s_rx;
    logic        prev_sclk = 1'b0, prev_mosi = 1'b0, lead_e, trail_e;

    // Transaction-level model of held chip selects
    logic        held    [3];
    logic [2:0]  held_sel[3];
    logic [3:0]  held_m  [3];

    assign miso = lp ? o_mosi : s_miso;

    mv_spimaster_multi #(.DATA_W(8), .NUM_CS(4), .CS_SEL_W(3), .CLK_DIV(2)) u_dut0 (
        .clk(clk), .reset(rst), .rw_req(rw_req[0]), .wr_data(wr_data[0][7:0]),
        .cs_sel(cs_sel[0]), .cpol(cpol[0]), .cpha(cpha[0]), .lsb_first(lsbf[0]),
        .hold_cs(hold[0]), .rd_data(rd0), .rd_strobe(stb0), .ready(rdy0),
        .sclk(sck0), .mosi(mo0), .miso(miso), .cs_n(csn0));

    mv_spimaster_multi #(.DATA_W(16), .NUM_CS(4), .CS_SEL_W(3), .CLK_DIV(2)) u_dut1 (
        .clk(clk), .reset(rst), .rw_req(rw_req[1]), .wr_data(wr_data[1][15:0]),
        .cs_sel(cs_sel[1]), .cpol(cpol[1]), .cpha(cpha[1]), .lsb_first(lsbf[1]),
        .hold_cs(hold[1]), .rd_data(rd1), .rd_strobe(stb1), .ready(rdy1),
        .sclk(sck1), .mosi(mo1), .miso(miso), .cs_n(csn1));

    mv_spimaster_multi #(.DATA_W(8), .NUM_CS(4), .CS_SEL_W(3), .CLK_DIV(1)) u_dut2 (
        .clk(clk), .reset(rst), .rw_req(rw_req[2]), .wr_data(wr_data[2][7:0]),
        .cs_sel(cs_sel[2]), .cpol(cpol[2]), .cpha(cpha[2]), .lsb_first(lsbf[2]),
        .hold_cs(hold[2]), .rd_data(rd2), .rd_strobe(stb2), .ready(rdy2),
        .sclk(sck2), .mosi(mo2), .miso(miso), .cs_n(csn2));

    // Route the selected build's outputs to the common observation signals
    always_comb begin
        case (cur)
            0: begin
                o_rd = {24'b0, rd0}; o_stb = stb0; o_rdy = rdy0;
                o_sclk = sck0; o_mosi = mo0; o_csn = csn0;
            end
            1: begin
                o_rd = {16'b0, rd1}; o_stb = stb1; o_rdy = rdy1;
                o_sclk = sck1; o_mosi = mo1; o_csn = csn1;
            end
            default: begin
                o_rd = {24'b0, rd2}; o_stb = stb2; o_rdy = rdy2;
                o_sclk = sck2; o_mosi = mo2; o_csn = csn2;
            end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Bit k of the word the slave returns, in wire order
    function automatic logic sbit(input int k);
        if (k >= m_w) return 1'b0;
        return m_lsb ? m_sdata[k] : m_sdata[m_w-1-k];
    endfunction

    // SPI slave: reacts to SCLK edges, captures mosi, shifts out its word
    always @(negedge clk) begin
        if (arm && !armed_q) begin
            idx = 0; n_lead = 0; n_trail = 0; n_cap = 0; mo_bad = 0; s_rx = '0;
            s_miso = m_pha ? 1'b0 : sbit(0);
        end else if (armed_q) begin
            lead_e  = (o_sclk != prev_sclk) && (o_sclk != m_pol);
            trail_e = (o_sclk != prev_sclk) && (o_sclk == m_pol);
            if ((o_mosi != prev_mosi) && (n_trail < m_w) &&
                !(m_pha ? lead_e : (trail_e || n_lead == 0)))
                mo_bad++;
            if (lead_e) begin
                n_lead++;
                if (!m_pha) begin
                    if (m_lsb) s_rx[n_cap] = o_mosi; else s_rx = {s_rx[30:0], o_mosi};
                    n_cap++;
                end else begin
                    s_miso = sbit(idx); idx++;
                end
            end
            if (trail_e) begin
                n_trail++;
                if (m_pha) begin
                    if (m_lsb) s_rx[n_cap] = o_mosi; else s_rx = {s_rx[30:0], o_mosi};
                    n_cap++;
                end else begin
                    idx++; s_miso = sbit(idx);
                end
            end
        end
        armed_q   = arm;
        prev_sclk = o_sclk;
        prev_mosi = o_mosi;
    end

    task automatic run_xfer(input int d, input logic [31:0] data_in, input logic [2:0] sel,
                            input logic pol, input logic pha, input logic lsb, input logic hld,
                            input logic loop, input logic [31:0] sdata_in, input logic poke);
        int W, CD, L, g, cyc, bad, extra;
        logic [31:0] data, sdata;
        logic [3:0] exp_mask, pre_mask;
        logic gap, first, found;
        W = DWV[d]; CD = CDV[d];
        data  = data_in  & ((32'h1 << W) - 1);
        sdata = sdata_in & ((32'h1 << W) - 1);
        cur = d;
        @(negedge clk);
        wr_data[d] = data; cs_sel[d] = sel; cpol[d] = pol; cpha[d] = pha;
        lsbf[d] = lsb; hold[d] = hld; rw_req[d] = 1'b0; lp = loop;
        m_w = W; m_sdata = sdata; m_pol = pol; m_pha = pha; m_lsb = lsb;
        exp_mask = (sel < 3'd4) ? ~(4'b1 << sel) : 4'hF;
        pre_mask = held[d] ? held_m[d] : 4'hF;
        gap = held[d] && (sel != held_sel[d]);
        g   = gap ? CD : 0;
        L   = CD * (2 * W + 2) + g;
        bad = 0; first = 1'b0;
        @(negedge clk);
        if (o_csn !== pre_mask) bad++;
        @(posedge clk); #1 arm = 1'b1;
        @(negedge clk);
        if (o_csn !== pre_mask) bad++;
        check("ready_before", o_rdy, 1'b1);
        rw_req[d] = 1'b1;
        @(posedge clk); #1;
        rw_req[d] = 1'b0;
        // Config changes after acceptance must not affect the word in flight
        wr_data[d] = $urandom; cs_sel[d] = 3'($urandom); cpha[d] = 1'($urandom);
        lsbf[d] = 1'($urandom); hold[d] = 1'($urandom);
        cyc = 0;
        while (cyc <= L + CD + 20) begin
            if (o_stb) break;
            if (o_csn !== ((cyc < g) ? 4'hF : exp_mask)) bad++;
            if (o_rdy) bad++;
            if (cyc == g) first = o_mosi;
            rw_req[d] = poke && (cyc == L / 2);
            @(posedge clk); #1;
            cyc++;
        end
        rw_req[d] = 1'b0;
        found = o_stb;
        check("strobe_seen", found, 1'b1);
        check("latency", cyc, L);
        check("rd_data", o_rd, loop ? data : sdata);
        check("cs_at_done", o_csn, hld ? exp_mask : 4'hF);
        check("sclk_at_done", o_sclk, pol);
        check("cs_during", bad, 0);
        check("slave_saw_mosi", s_rx, data);
        check("sclk_edges", n_lead, W);
        check("mosi_timing", mo_bad, 0);
        if (!pha) check("first_mosi", first, lsb ? data[0] : data[W-1]);
        arm = 1'b0;
        held[d] = hld && (sel < 3'd4); held_sel[d] = sel; held_m[d] = exp_mask;
        @(posedge clk); #1;
        check("ready_after", o_rdy, 1'b1);
        check("sclk_idle", o_sclk, pol);
        extra = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (o_stb || !o_rdy) extra++;
        end
        check("no_requeue", extra, 0);
    endtask

    task automatic reset_mid(input int d, input int k);
        cur = d;
        @(negedge clk);
        wr_data[d] = 32'h5A; cs_sel[d] = 3'd1; cpol[d] = 1'b1; cpha[d] = 1'b0;
        lsbf[d] = 1'b0; hold[d] = 1'b0;
        rw_req[d] = 1'b1;
        @(posedge clk); #1 rw_req[d] = 1'b0;
        repeat (k) @(posedge clk);
        @(negedge clk); #1 rst = 1'b1;
        #1;
        check("rst_cs_n", o_csn, 4'hF);
        check("rst_sclk", o_sclk, 1'b0);
        check("rst_ready", o_rdy, 1'b1);
        check("rst_strobe", o_stb, 1'b0);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 3; i++) held[i] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            rw_req[i] = 1'b0; wr_data[i] = '0; cs_sel[i] = '0; cpol[i] = 1'b0;
            cpha[i] = 1'b0; lsbf[i] = 1'b0; hold[i] = 1'b0;
            held[i] = 1'b0; held_sel[i] = '0; held_m[i] = 4'hF;
        end
        s_miso = 1'b0; m_pol = 1'b0; m_pha = 1'b0; m_lsb = 1'b0; m_sdata = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            cur = i; #1;
            check("reset_ready", o_rdy, 1'b1);
            check("reset_cs_n", o_csn, 4'hF);
            check("reset_sclk", o_sclk, 1'b0);
            check("reset_mosi", o_mosi, 1'b0);
            check("reset_rd", {o_stb, o_rd}, '0);
        end
        @(negedge clk) rst = 1'b0;

        // Loopback mode 0, then mode 3 against the slave model
        run_xfer(0, 32'hA5, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
        run_xfer(0, 32'h81, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h3C, 1'b0);
        // LSB first, 8 and 16 bit
        run_xfer(0, 32'h01, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
        run_xfer(1, 32'h8001, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
        // Held select on slave 2 across two words, then a switch to slave 0
        run_xfer(0, 32'h11, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hC3, 1'b0);
        run_xfer(0, 32'h22, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h96, 1'b0);
        run_xfer(0, 32'h33, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h69, 1'b0);
        // Request pulsed mid-transfer, reset mid-word, recovery
        run_xfer(0, 32'h7E, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hE7, 1'b1);
        reset_mid(0, 9);
        run_xfer(0, 32'hC6, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h5D, 1'b0);
        // Divider of 1, mode 1, out-of-range select
        run_xfer(2, 32'h4B, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hB2, 1'b0);

        // Random traffic on all builds
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 20; n++) begin
                run_xfer(d, $urandom, 3'($urandom_range(0, 5)), 1'($urandom),
                         1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                         $urandom, 1'($urandom_range(0, 3) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
